mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter sharing the single-port unified instruction/data memory between the core's instruction-fetch port (IF) and load/store port (LS). It sits between `core` and the memory inside `mycore_soc`, granting at most one access per cycle and routing read data back to the winner after the memory's fixed read latency. It replaces the dedicated fetch path, so one memory image serves both fetch and load/store.

## Interface
- `RD_LAT`, 1, memory read latency in cycles, legal range 1..4.
- `AW`, 32, address width; word address is `addr[AW-1:2]`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request, held until granted.
- `if_addr`  in  AW  fetch byte address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid.
- `if_rdata`  out  32  fetched instruction.
- `ls_req`  in  1  load/store request, held until granted.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  AW  data byte address.
- `ls_wdata`  in  32  store data.
- `ls_wstrb`  in  4  byte enables for a store.
- `ls_gnt`  out  1  load/store accepted this cycle.
- `ls_rvalid`  out  1  `ls_rdata` valid (loads only).
- `ls_rdata`  out  32  load data.
- `mem_ce`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW-2  word address.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  byte enables.
- `mem_rdata`  in  32  read data, valid `RD_LAT` cycles after `mem_ce`.

## Operation
- Each cycle, choose a winner among the asserted requests. Drive `mem_*` from the winner and pulse its `*_gnt`.
- Default priority is LS over IF, so a stalled load/store never waits behind fetch.
- A grant with `we=0` pushes an owner tag (IF or LS) into an `RD_LAT`-deep shift register. A store pushes an empty tag.
- When a tag reaches the output stage, pulse that owner's `*_rvalid`.
- `if_rdata` and `ls_rdata` both pass `mem_rdata` through directly. Only the `rvalid` signals qualify them.
- Stores complete at grant. They produce no `rvalid`.
- Requesters hold `req`, `addr`, `we`, `wdata` and `wstrb` stable until `gnt`. The arbiter does not latch request fields.
- With no request, `mem_ce` = 0 and `mem_*` are don't-care; an empty tag is pushed.
- `last_win` register: records the winner of the most recent grant. Cleared to IF on reset.

## Timing
- Grant is combinational: a request in cycle N is granted in cycle N if it wins.
- `mem_ce` is asserted in cycle N for an access granted in cycle N.
- Read `rvalid` is asserted in cycle N+`RD_LAT`.
- Fully pipelined: one grant per cycle, with back-to-back reads from either port. Responses return in grant order.
- Both ports requesting in the same cycle: exactly one `gnt`. The loser keeps its request asserted and is considered again next cycle.
- Reset values: `if_gnt`, `ls_gnt`, `if_rvalid`, `ls_rvalid`, `mem_ce`, `mem_we` = 0. Owner pipe holds all-empty tags. `last_win` = IF.
- Reset mid-operation: in-flight tags are dropped and no `rvalid` is issued for them. The first grant is possible in the first cycle with `rst`=1.

## Configuration
- `MEM_ARB_FAIR_EN` defined: when `last_win` = LS and both ports request, IF wins. Under continuous contention the ports alternate, bounding fetch starvation to 1 cycle.
- `MEM_ARB_FAIR_EN` undefined: fixed LS priority; `last_win` is not implemented. IF waits while `ls_req` stays high.

## Structure
- Add the tag encodings (`TAG_NONE`, `TAG_IF`, `TAG_LS`) and the `RD_LAT` bound to `defines.v`. Data widths use the existing `` `RegBus ``.
- Put the owner-tag shift register and its `rvalid` decode in one sub-module, `mem_arb_rsp_pipe`.
- Keep grant selection and the memory mux in `mem_port_arbiter`.

## Test plan
- IF only, `if_addr` = 0x0, 0x4, 0x8 on consecutive cycles, `RD_LAT`=1 → three grants, then `if_rvalid` in three consecutive cycles with memory words 0, 1, 2.
- Same-cycle IF read of 0x10 and LS load of 0x20 → `ls_gnt` first, then `if_gnt` next cycle. `ls_rvalid` and `if_rvalid` follow in order, with the correct words.
- LS store 0xDEADBEEF to 0x40 with `wstrb`=4'b0011, then LS load of 0x40 → read returns 0x????BEEF merged with the old upper half. No `rvalid` is issued for the store.
- `ls_req` and `if_req` both held high for 6 cycles → with `MEM_ARB_FAIR_EN`, grants alternate LS, IF, LS, IF, LS, IF. Without it, all six are LS grants and `if_gnt` stays 0.
- `RD_LAT`=3, reads granted in cycles 0, 1, 2 → `rvalid` in cycles 3, 4, 5 with matching owners.
- `rst` pulled low one cycle after a read grant → no `rvalid` is emitted. All outputs are 0 during reset. A new grant is issued on the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, owner-tag encodings and latency bounds for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int REG_BUS    = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Owner of an in-flight memory read; stores and idle cycles carry TAG_NONE.
  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_IF   = 2'b01,
    TAG_LS   = 2'b10
  } tag_t;

  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_LS = 1'b1
  } win_t;

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// rtl/mem_arb_rsp_pipe.sv - RD_LAT-deep owner-tag shift register with per-port rvalid decode
module mem_arb_rsp_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] push_tag,
  output logic       if_rvalid,
  output logic       ls_rvalid
);

  logic [1:0] pipe [RD_LAT];

  // Reset flushes every in-flight tag so no response is reported for dropped reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= TAG_NONE;
      end
    end else begin
      pipe[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign if_rvalid = (pipe[RD_LAT-1] == TAG_IF);
  assign ls_rvalid = (pipe[RD_LAT-1] == TAG_LS);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and load/store ports (optional MEM_ARB_FAIR_EN alternation)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [AW-1:0]      if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [REG_BUS-1:0] if_rdata,
  input  logic               ls_req,
  input  logic               ls_we,
  input  logic [AW-1:0]      ls_addr,
  input  logic [REG_BUS-1:0] ls_wdata,
  input  logic [3:0]         ls_wstrb,
  output logic               ls_gnt,
  output logic               ls_rvalid,
  output logic [REG_BUS-1:0] ls_rdata,
  output logic               mem_ce,
  output logic               mem_we,
  output logic [AW-3:0]      mem_addr,
  output logic [REG_BUS-1:0] mem_wdata,
  output logic [3:0]         mem_wstrb,
  input  logic [REG_BUS-1:0] mem_rdata
);

  logic       if_win;
  logic       ls_win;
  logic [1:0] push_tag;
  logic       unused_addr_lsb;

`ifdef MEM_ARB_FAIR_EN
  win_t last_win;

  // Under contention, IF takes the slot right after an LS grant, so the ports alternate.
  always_comb begin
    ls_win = rst & ls_req & ~(if_req & (last_win == WIN_LS));
    if_win = rst & if_req & ~ls_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win <= WIN_IF;
    end else if (ls_win) begin
      last_win <= WIN_LS;
    end else if (if_win) begin
      last_win <= WIN_IF;
    end
  end
`else
  always_comb begin
    ls_win = rst & ls_req;
    if_win = rst & if_req & ~ls_req;
  end
`endif

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign mem_ce    = if_win | ls_win;
  assign mem_we    = ls_win & ls_we;
  assign mem_addr  = ls_win ? ls_addr[AW-1:2] : if_addr[AW-1:2];
  assign mem_wdata = ls_wdata;
  assign mem_wstrb = (ls_win & ls_we) ? ls_wstrb : 4'b0000;

  always_comb begin
    push_tag = TAG_NONE;
    if (ls_win && !ls_we) begin
      push_tag = TAG_LS;
    end else if (if_win) begin
      push_tag = TAG_IF;
    end
  end

  mem_arb_rsp_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .if_rvalid(if_rvalid),
    .ls_rvalid(ls_rvalid)
  );

  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

  assign unused_addr_lsb = ^{if_addr[1:0], ls_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter at RD_LAT 1 and 3
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;

  logic        g1_if, g1_ls, rv1_if, rv1_ls, ce1, we1;
  logic [31:0] rd1_if, rd1_ls, wd1, m1_rdata;
  logic [29:0] a1;
  logic [3:0]  ws1;

  logic        g3_if, g3_ls, rv3_if, rv3_ls, ce3, we3;
  logic [31:0] rd3_if, rd3_ls, wd3, m3_rdata;
  logic [29:0] a3;
  logic [3:0]  ws3;

  mem_port_arbiter #(.RD_LAT(1), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(g1_if), .if_rvalid(rv1_if), .if_rdata(rd1_if),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(g1_ls), .ls_rvalid(rv1_ls), .ls_rdata(rd1_ls),
    .mem_ce(ce1), .mem_we(we1), .mem_addr(a1), .mem_wdata(wd1), .mem_wstrb(ws1), .mem_rdata(m1_rdata)
  );

  mem_port_arbiter #(.RD_LAT(3), .AW(32)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(g3_if), .if_rvalid(rv3_if), .if_rdata(rd3_if),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(g3_ls), .ls_rvalid(rv3_ls), .ls_rdata(rd3_ls),
    .mem_ce(ce3), .mem_we(we3), .mem_addr(a3), .mem_wdata(wd3), .mem_wstrb(ws3), .mem_rdata(m3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i initialised to byte i replicated; writes come from the RD_LAT=1 instance.
  logic [31:0] mem [256];
  logic [31:0] rpipe3 [3];
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i] = {b, b, b, b};
    end
  end

  always @(posedge clk) begin
    if (ce1 && we1) begin
      for (int k = 0; k < 4; k++) begin
        if (ws1[k]) mem[a1[7:0]][8*k +: 8] <= wd1[8*k +: 8];
      end
    end
    m1_rdata  <= mem[a1[7:0]];
    rpipe3[0] <= mem[a3[7:0]];
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign m3_rdata = rpipe3[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic        e_if_rv;
    logic        e_ls_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                              input logic [31:0] la, input logic [31:0] ld, input logic [3:0] ls,
                              input logic eig, input logic elg, input logic eir, input logic elr,
                              input logic [31:0] ed);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la;
    v.ls_wdata = ld; v.ls_wstrb = ls;
    v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_if_rv = eir; v.e_ls_rv = elr; v.e_rdata = ed;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld, input logic [3:0] ls);
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld; ls_wstrb = ls;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " outs1"}, {31'd0, g1_if | g1_ls | rv1_if | rv1_ls | ce1 | we1}, 32'd0);
    chk({tag, " outs3"}, {31'd0, g3_if | g3_ls | rv3_if | rv3_ls | ce3 | we3}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e_if3 [6];
    logic e_ls3 [6];
    logic [31:0] e_d3 [6];

    vecs[0]  = mk(1, 32'h00, 0, 0, 0, 0, 0,                          1, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 32'h04, 0, 0, 0, 0, 0,                          1, 0, 1, 0, 32'h00000000);
    vecs[2]  = mk(1, 32'h08, 0, 0, 0, 0, 0,                          1, 0, 1, 0, 32'h01010101);
    vecs[3]  = mk(0, 32'h00, 0, 0, 0, 0, 0,                          0, 0, 1, 0, 32'h02020202);
    vecs[4]  = mk(1, 32'h10, 1, 0, 32'h20, 0, 0,                     0, 1, 0, 0, 32'h0);
    vecs[5]  = mk(1, 32'h10, 0, 0, 0, 0, 0,                          1, 0, 0, 1, 32'h08080808);
    vecs[6]  = mk(0, 32'h00, 0, 0, 0, 0, 0,                          0, 0, 1, 0, 32'h04040404);
    vecs[7]  = mk(0, 32'h00, 1, 1, 32'h40, 32'hDEADBEEF, 4'b0011,    0, 1, 0, 0, 32'h0);
    vecs[8]  = mk(0, 32'h00, 1, 0, 32'h40, 0, 0,                     0, 1, 0, 0, 32'h0);
    vecs[9]  = mk(1, 32'h0C, 0, 0, 0, 0, 0,                          1, 0, 0, 1, 32'h1010BEEF);
    for (int k = 0; k < 6; k++) begin
      logic lg, prev_ls;
      lg = FAIR ? (k % 2 == 0) : 1'b1;
      prev_ls = FAIR ? (k % 2 == 1) : 1'b1;
      if (k == 0)
        vecs[10] = mk(1, 32'h00, 1, 0, 32'h04, 0, 0, 0, 1, 1, 0, 32'h03030303);
      else
        vecs[10+k] = mk(1, 32'h00, 1, 0, 32'h04, 0, 0, ~lg, lg, ~prev_ls, prev_ls,
                        prev_ls ? 32'h01010101 : 32'h00000000);
    end
    vecs[16] = mk(0, 32'h00, 0, 0, 0, 0, 0, 0, 0, FAIR, ~FAIR, FAIR ? 32'h0 : 32'h01010101);

    rst = 1'b0;
    drive(1, 32'h0, 1, 0, 32'h4, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_all_zero($sformatf("reset%0d", c));
    end
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_we,
            vecs[i].ls_addr, vecs[i].ls_wdata, vecs[i].ls_wstrb);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i), {31'd0, g1_if}, {31'd0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d ls_gnt", i), {31'd0, g1_ls}, {31'd0, vecs[i].e_ls_gnt});
      chk($sformatf("v%0d if_rvalid", i), {31'd0, rv1_if}, {31'd0, vecs[i].e_if_rv});
      chk($sformatf("v%0d ls_rvalid", i), {31'd0, rv1_ls}, {31'd0, vecs[i].e_ls_rv});
      if (vecs[i].e_if_rv) chk($sformatf("v%0d if_rdata", i), rd1_if, vecs[i].e_rdata);
      if (vecs[i].e_ls_rv) chk($sformatf("v%0d ls_rdata", i), rd1_ls, vecs[i].e_rdata);
      next_cycle();
    end

    // RD_LAT=3: IF, LS, IF reads back to back, responses three cycles later in order.
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) next_cycle();
    e_if3 = '{0, 0, 0, 1, 0, 1};
    e_ls3 = '{0, 0, 0, 0, 1, 0};
    e_d3  = '{0, 0, 0, 32'h00000000, 32'h02020202, 32'h01010101};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(1, 32'h0, 0, 0, 0, 0, 0);
        1:       drive(0, 32'h0, 1, 0, 32'h8, 0, 0);
        2:       drive(1, 32'h4, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      chk($sformatf("lat3 c%0d if_rvalid", c), {31'd0, rv3_if}, {31'd0, e_if3[c]});
      chk($sformatf("lat3 c%0d ls_rvalid", c), {31'd0, rv3_ls}, {31'd0, e_ls3[c]});
      if (e_if3[c]) chk($sformatf("lat3 c%0d if_rdata", c), rd3_if, e_d3[c]);
      if (e_ls3[c]) chk($sformatf("lat3 c%0d ls_rdata", c), rd3_ls, e_d3[c]);
      next_cycle();
    end

    // Reset one cycle after a read grant drops the in-flight response.
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstseq grant", {31'd0, g1_if}, 32'd1);
    next_cycle();
    rst = 1'b0;
    drive(1, 32'h8, 1, 0, 32'h4, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_all_zero($sformatf("midrst%0d", c));
      next_cycle();
    end
    rst = 1'b1;
    drive(1, 32'hC, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("release if_gnt", {31'd0, g1_if}, 32'd1);
    chk("release rv1", {31'd0, rv1_if | rv1_ls}, 32'd0);
    chk("release rv3", {31'd0, rv3_if | rv3_ls}, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post rv1 if", {31'd0, rv1_if}, 32'd1);
    chk("post rd1 if", rd1_if, 32'h03030303);
    chk("post rv3 a", {31'd0, rv3_if | rv3_ls}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post rv3 b", {31'd0, rv3_if | rv3_ls}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post rv3 if", {31'd0, rv3_if}, 32'd1);
    chk("post rd3 if", rd3_if, 32'h03030303);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
